// File: rtl/p_circuit_pkg.sv
// Shared types and helpers for the p-bit circuit: scheduler states, input range
// and accumulator width.
package p_circuit_pkg;

  localparam int ACC_W = 16;
  localparam int I_MAX = 127;
  localparam int I_MIN = -128;

  localparam logic signed [ACC_W-1:0] ACC_I_MAX = ACC_W'(I_MAX);
  localparam logic signed [ACC_W-1:0] ACC_I_MIN = ACC_W'(I_MIN);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    UPDATE
  } sched_state_t;

  // Clamp the wide weighted sum into the 8-bit signed range the p-bit accepts.
  function automatic logic signed [7:0] sat_to_i8(input logic signed [ACC_W-1:0] a);
    if (a > ACC_I_MAX) return 8'sh7f;
    if (a < ACC_I_MIN) return 8'sh80;
    return a[7:0];
  endfunction

endpackage

// File: rtl/tm_synapse_scheduler_if.sv
// Scheduler-side bundle: weight RAM port, p-bit update port, run control and status.
interface tm_synapse_scheduler_if #(
  parameter int N_PBITS = 8,
  parameter int W_W     = 8
);
  localparam int IDX_W  = $clog2(N_PBITS);
  localparam int ADDR_W = $clog2(N_PBITS * N_PBITS);

  logic                    run;
  logic [ADDR_W-1:0]       w_addr;
  logic signed [W_W-1:0]   w_data;
  logic signed [7:0]       I_i;
  logic [IDX_W-1:0]        p_sel;
  logic                    p_enable;
  logic                    m_in;
  logic [N_PBITS-1:0]      m_state;
  logic                    busy;
  logic                    sweep_done;

  modport master (
    input  run, w_data, m_in,
    output w_addr, I_i, p_sel, p_enable, m_state, busy, sweep_done
  );

  modport slave (
    output run, w_data, m_in,
    input  w_addr, I_i, p_sel, p_enable, m_state, busy, sweep_done
  );
endinterface

// File: rtl/tm_mac_accum.sv
// Sign-select and accumulate: adds +w or -w (sign-extended) each enabled cycle,
// with synchronous clear. acc_next is the value the register takes at the next edge.
module tm_mac_accum
  import p_circuit_pkg::*;
#(
  parameter int W_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    neg,
  input  logic signed [W_W-1:0]   w,
  output logic signed [ACC_W-1:0] acc_next
);
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;

  // ACC_W exceeds W_W, so negating the most negative weight cannot wrap.
  always_comb begin
    term = {{(ACC_W - W_W){w[W_W-1]}}, w};
    if (neg) term = -term;
    if (clr)     acc_next = '0;
    else if (en) acc_next = acc + term;
    else         acc_next = acc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc <= '0;
    else          acc <= acc_next;
  end
endmodule

// File: rtl/tm_synapse_scheduler.sv
// Round-robin synapse scheduler: per p-bit, stream weight row i, form the signed
// weighted input, strobe the p-bit and latch its new state.
//   state  | meaning
//   IDLE   | waiting for run; no p-bit targeted
//   ACCUM  | N_PBITS+1 cycles: address row i, accumulate terms one cycle behind
//   UPDATE | one cycle: drive saturated I_i with p_enable, capture m_in at the closing edge
module tm_synapse_scheduler
  import p_circuit_pkg::*;
#(
  parameter int N_PBITS = 8,
  parameter int W_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  tm_synapse_scheduler_if.master bus
);
  localparam int IDX_W  = $clog2(N_PBITS);
  localparam int ADDR_W = $clog2(N_PBITS * N_PBITS);
  localparam int CNT_W  = $clog2(N_PBITS + 1);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_PBITS - 1);
  localparam logic [CNT_W-1:0] K_LAST_ADDR = CNT_W'(N_PBITS - 1);
  localparam logic [CNT_W-1:0] K_FINAL     = CNT_W'(N_PBITS);

  sched_state_t            state;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        k;
  logic [ADDR_W-1:0]       row_base;
  logic [IDX_W-1:0]        j_idx;
  logic                    mac_clr;
  logic                    mac_en;
  logic                    mac_neg;
  logic signed [ACC_W-1:0] acc_next;

  // RAM data lags the address by one cycle, so the term added in cycle k is j=k-1.
  always_comb begin
    row_base = ADDR_W'(idx) * ADDR_W'(N_PBITS);
    j_idx    = IDX_W'(k - CNT_W'(1));
    mac_clr  = (state != ACCUM);
    mac_en   = (state == ACCUM) && (k != '0);
    mac_neg  = (j_idx != idx) && !bus.m_state[j_idx];
  end

  tm_mac_accum #(.W_W(W_W)) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (mac_clr),
    .en       (mac_en),
    .neg      (mac_neg),
    .w        (bus.w_data),
    .acc_next (acc_next)
  );

  assign bus.p_sel = idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= '0;
      k              <= '0;
      bus.w_addr     <= '0;
      bus.I_i        <= '0;
      bus.p_enable   <= 1'b0;
      bus.m_state    <= '0;
      bus.busy       <= 1'b0;
      bus.sweep_done <= 1'b0;
    end else begin
      bus.p_enable   <= 1'b0;
      bus.sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run) begin
            state      <= ACCUM;
            idx        <= '0;
            k          <= '0;
            bus.w_addr <= '0;
            bus.busy   <= 1'b1;
          end
        end
        ACCUM: begin
          if (k < K_LAST_ADDR) bus.w_addr <= row_base + ADDR_W'(k) + ADDR_W'(1);
          if (k == K_FINAL) begin
            state          <= UPDATE;
            bus.I_i        <= sat_to_i8(acc_next);
            bus.p_enable   <= 1'b1;
            bus.sweep_done <= (idx == LAST_IDX);
          end else begin
            k <= k + CNT_W'(1);
          end
        end
        UPDATE: begin
          bus.m_state[idx] <= bus.m_in;
          k                <= '0;
          if (idx != LAST_IDX) begin
            idx        <= idx + IDX_W'(1);
            bus.w_addr <= row_base + ADDR_W'(N_PBITS);
            state      <= ACCUM;
          end else begin
            idx        <= '0;
            bus.w_addr <= '0;
            if (bus.run) begin
              state <= ACCUM;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tm_synapse_scheduler.sv
// Scoreboard bench for tm_synapse_scheduler with N_PBITS=4: stimulus queues the
// expected p-bit updates, a monitor pops and compares on every p_enable.
module tb_tm_synapse_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tm_synapse_scheduler_if #(.N_PBITS(N), .W_W(8)) bus ();
  tm_synapse_scheduler #(.N_PBITS(N), .W_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic signed [7:0] ram [N*N];
  always @(posedge clk) bus.w_data <= ram[bus.w_addr];

  typedef struct {
    int psel;
    int ii;
    int last;
    int gap;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int psel, input int ii, input int last, input int gap);
    exp_t e;
    e.psel = psel; e.ii = ii; e.last = last; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: every update strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    int last_en;
    last_en = -1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        last_en = -1;
      end else if (bus.p_enable) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_enable: p_sel=%0d I_i=%0d with nothing expected", bus.p_sel, $signed(bus.I_i));
        end else begin
          e = exp_q.pop_front();
          check("p_sel", int'(bus.p_sel), e.psel);
          check("I_i", int'($signed(bus.I_i)), e.ii);
          check("sweep_done_at_update", int'(bus.sweep_done), e.last);
          if (e.gap > 0 && last_en >= 0) check("enable_gap", cyc - last_en, e.gap);
        end
        last_en = cyc;
      end else if (bus.sweep_done) begin
        checks++; errors++;
        $display("FAIL stray_sweep_done: got 1 outside update, expected 0");
      end
    end
  end

  task automatic clear_ram();
    for (int a = 0; a < N*N; a++) ram[a] = 8'sd0;
  endtask

  task automatic do_reset();
    bus.run = 1'b0;
    bus.m_in = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic start_run(output int t0);
    @(negedge clk); bus.run = 1'b1;
    @(posedge clk); #1 t0 = cyc;
  endtask

  task automatic wait_done(input string name, output int t);
    t = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.sweep_done) begin t = cyc; break; end
    end
    if (t < 0) begin checks++; errors++; $display("FAIL %s: sweep_done timeout, got none, expected pulse", name); end
  endtask

  task automatic wait_enable(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.p_enable) begin seen = 1'b1; break; end
    end
    if (!seen) begin checks++; errors++; $display("FAIL %s: p_enable timeout, got none, expected pulse", name); end
  endtask

  task automatic wait_psel_accum(input string name, input int v);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.busy && !bus.p_enable && int'(bus.p_sel) == v) begin seen = 1'b1; break; end
    end
    if (!seen) begin checks++; errors++; $display("FAIL %s: p_sel never reached %0d", name, v); end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_I_i"}, int'($signed(bus.I_i)), 0);
    check({tag, "_p_sel"}, int'(bus.p_sel), 0);
    check({tag, "_p_enable"}, int'(bus.p_enable), 0);
    check({tag, "_w_addr"}, int'(bus.w_addr), 0);
    check({tag, "_m_state"}, int'(bus.m_state), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_sweep_done"}, int'(bus.sweep_done), 0);
  endtask

  initial begin
    int t0, t1, t2;
    bus.run = 1'b0;
    bus.m_in = 1'b0;
    clear_ram();
    #1 reset_n = 1'b0;
    #1 check_zero_outputs("reset");
    @(negedge clk); reset_n = 1'b1;

    // Bias only: every p-bit sees +5, sweep ends on cycle 24.
    for (int i = 0; i < N; i++) ram[i*N+i] = 8'sd5;
    push(0, 5, 0, -1); push(1, 5, 0, 6); push(2, 5, 0, 6); push(3, 5, 1, 6);
    start_run(t0);
    @(negedge clk); bus.run = 1'b0;
    wait_done("bias_sweep", t1);
    check("bias_done_cycle", t1 - t0 + 1, 24);
    repeat (3) @(negedge clk);
    check("bias_idle_busy", int'(bus.busy), 0);
    check("bias_q_empty", exp_q.size(), 0);

    // Off-diagonal weights against a -1 state vector.
    do_reset();
    clear_ram();
    ram[1] = 8'sd10; ram[2] = 8'sd10; ram[3] = 8'sd10;
    bus.m_in = 1'b1;
    push(0, -30, 0, -1); push(1, 0, 0, 6); push(2, 0, 0, 6); push(3, 0, 1, 6);
    start_run(t0);
    @(negedge clk); bus.run = 1'b0;
    wait_enable("offdiag_first");
    @(negedge clk);
    check("offdiag_m_state_p0", int'(bus.m_state), 1);
    wait_done("offdiag_sweep", t1);
    repeat (3) @(negedge clk);
    check("offdiag_m_state_end", int'(bus.m_state), 15);
    check("offdiag_q_empty", exp_q.size(), 0);

    // Saturation both ways over two back-to-back sweeps.
    do_reset();
    for (int a = 0; a < N*N; a++) ram[a] = 8'sd100;
    bus.m_in = 1'b1;
    push(0, -128, 0, -1); push(1, 0, 0, 6); push(2, 127, 0, 6); push(3, 127, 1, 6);
    push(0, 127, 0, 6); push(1, 127, 0, 6); push(2, 127, 0, 6); push(3, 127, 1, 6);
    start_run(t0);
    wait_done("sat_sweep1", t1);
    @(negedge clk);
    check("sat_m_state_sweep1", int'(bus.m_state), 15);
    @(negedge clk); bus.run = 1'b0;
    wait_done("sat_sweep2", t2);
    check("sat_done_interval", t2 - t1, 24);
    repeat (3) @(negedge clk);
    check("sat_idle_busy", int'(bus.busy), 0);
    check("sat_q_empty", exp_q.size(), 0);

    // run dropped at p_sel=1; includes negation of -128 and mixed signs.
    do_reset();
    clear_ram();
    for (int i = 0; i < N; i++) ram[i*N+i] = 8'(i + 1);
    ram[2*N+0] = -8'sd128;
    ram[3*N+1] = -8'sd50;
    ram[3*N+2] = 8'sd20;
    push(0, 1, 0, -1); push(1, 2, 0, 6); push(2, 127, 0, 6); push(3, 34, 1, 6);
    start_run(t0);
    wait_psel_accum("drop_wait", 1);
    bus.run = 1'b0;
    wait_done("drop_sweep", t1);
    repeat (30) @(negedge clk);
    check("drop_idle_busy", int'(bus.busy), 0);
    check("drop_q_empty", exp_q.size(), 0);

    // Async reset during ACCUM of p_sel=2, then restart from p_sel=0.
    do_reset();
    clear_ram();
    for (int i = 0; i < N; i++) ram[i*N+i] = 8'sd5;
    bus.m_in = 1'b1;
    push(0, 5, 0, -1); push(1, 5, 0, 6);
    start_run(t0);
    wait_psel_accum("rst_wait", 2);
    check("rst_m_state_before", int'(bus.m_state), 3);
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("midrst");
    check("midrst_q_empty", exp_q.size(), 0);
    push(0, 5, 0, -1); push(1, 5, 0, 6); push(2, 5, 0, 6); push(3, 5, 1, 6);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); bus.run = 1'b0;
    wait_done("rst_restart_sweep", t1);
    repeat (3) @(negedge clk);
    check("rst_m_state_end", int'(bus.m_state), 15);
    check("rst_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
